sync_fifo_modport: RTL and testbench

//  Single-clock FIFO with per-port ack/error handshake and almost-full/almost-empty flags.
//  Its signal set matches the afifo interface, so the write/read driver and monitor

---
 rtl/sync_fifo_modport.sv | 104 ++++++++++
 tb/tb_sync_fifo_modport.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_modport.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_modport
//  Purpose  : Single-clock FIFO with per-side ack/error pulses and
//             almost-full / almost-empty flags decoded from the entry count.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_modport #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             wr_ack,
    output logic             wr_err,
    output logic             full,
    output logic             almost_full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             rd_ack,
    output logic             rd_err,
    output logic             empty,
    output logic             almost_empty
);

    localparam int              c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_CNT_FULL  = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_AFULL = (c_AW+1)'(DEPTH - 1);
    localparam logic [c_AW:0]   c_CNT_ONE   = (c_AW+1)'(1);
    localparam logic [c_AW:0]   c_CNT_ZERO  = '0;
    localparam logic [c_AW-1:0] c_PTR_ONE   = c_AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_wr_ack;
    logic             r_wr_err;
    logic             r_rd_ack;
    logic             r_rd_err;

    logic             w_full;
    logic             w_empty;
    logic             w_rd_accept;
    logic             w_wr_accept;

    assign w_full      = (r_count == c_CNT_FULL);
    assign w_empty     = (r_count == c_CNT_ZERO);
    assign w_rd_accept = rd_en & ~w_empty;
    // A read on the same edge frees a slot, so a full FIFO still takes the write.
    assign w_wr_accept = wr_en & (~w_full | w_rd_accept);

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
            r_rd_ack <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_wr_ack <= w_wr_accept;
            r_wr_err <= wr_en & ~w_wr_accept;
            r_rd_ack <= w_rd_accept;
            r_rd_err <= rd_en & ~w_rd_accept;
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_accept) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign full         = w_full;
    assign almost_full  = (r_count == c_CNT_AFULL);
    assign empty        = w_empty;
    assign almost_empty = (r_count == c_CNT_ONE);
    assign dout         = r_dout;
    assign wr_ack       = r_wr_ack;
    assign wr_err       = r_wr_err;
    assign rd_ack       = r_rd_ack;
    assign rd_err       = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_modport.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_modport
//  Purpose  : Self-checking bench for sync_fifo_modport using a queue model
//             plus directed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_modport;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk;
    logic             clear_n;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             wr_ack;
    logic             wr_err;
    logic             full;
    logic             almost_full;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             rd_ack;
    logic             rd_err;
    logic             empty;
    logic             almost_empty;

    sync_fifo_modport #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .clear_n      (clear_n),
        .wr_en        (wr_en),
        .din          (din),
        .wr_ack       (wr_ack),
        .wr_err       (wr_err),
        .full         (full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .dout         (dout),
        .rd_ack       (rd_ack),
        .rd_err       (rd_err),
        .empty        (empty),
        .almost_empty (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: a queue of stored words plus last-cycle handshake results.
    logic [WIDTH-1:0] q[$];
    logic             m_wr_ack, m_wr_err, m_rd_ack, m_rd_err;
    logic [WIDTH-1:0] m_dout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_wr_ack = 1'b0;
        m_wr_err = 1'b0;
        m_rd_ack = 1'b0;
        m_rd_err = 1'b0;
        m_dout   = '0;
    endtask

    task automatic model_step();
        bit rd_ok, wr_ok;
        rd_ok = rd_en && (q.size() > 0);
        wr_ok = wr_en && ((q.size() < DEPTH) || rd_ok);
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(din);
        m_wr_ack = wr_ok;
        m_wr_err = wr_en && !wr_ok;
        m_rd_ack = rd_ok;
        m_rd_err = rd_en && !rd_ok;
    endtask

    // Compare DUT against the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_ack",       32'(wr_ack),       32'(m_wr_ack));
            check("wr_err",       32'(wr_err),       32'(m_wr_err));
            check("rd_ack",       32'(rd_ack),       32'(m_rd_ack));
            check("rd_err",       32'(rd_err),       32'(m_rd_err));
            check("dout",         32'(dout),         32'(m_dout));
            check("full",         32'(full),         32'(q.size() == DEPTH));
            check("almost_full",  32'(almost_full),  32'(q.size() == DEPTH - 1));
            check("empty",        32'(empty),        32'(q.size() == 0));
            check("almost_empty", 32'(almost_empty), 32'(q.size() == 1));
        end
    end

    task automatic cycle(input logic we, input logic [WIDTH-1:0] d, input logic re);
        wr_en = we;
        din   = d;
        rd_en = re;
        @(posedge clk);
        model_step();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        clear_n = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = '0;
        model_reset();

        // Reset asserted between edges must clear outputs immediately.
        #3 clear_n = 1'b0;
        #1;
        check("rst_empty",  32'(empty),  32'd1);
        check("rst_full",   32'(full),   32'd0);
        check("rst_dout",   32'(dout),   32'd0);
        check("rst_wr_ack", 32'(wr_ack), 32'd0);
        check("rst_rd_err", 32'(rd_err), 32'd0);
        @(negedge clk);
        clear_n = 1'b1;
        chk_en  = 1'b1;

        // Fill with 0x01..0x10, then one overflow write.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, WIDTH'(i), 1'b0);
            check("fill_wr_ack", 32'(wr_ack), 32'd1);
            if (i == DEPTH - 1) check("fill_afull", 32'(almost_full), 32'd1);
        end
        check("fill_full", 32'(full), 32'd1);
        cycle(1'b1, 8'h11, 1'b0);
        check("ovf_wr_err", 32'(wr_err), 32'd1);
        check("ovf_wr_ack", 32'(wr_ack), 32'd0);
        check("ovf_full",   32'(full),   32'd1);

        // Drain in order, then one underflow read.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, '0, 1'b1);
            check("drain_dout",   32'(dout),   32'(i));
            check("drain_rd_ack", 32'(rd_ack), 32'd1);
            if (i == DEPTH - 1) check("drain_aempty", 32'(almost_empty), 32'd1);
        end
        check("drain_empty", 32'(empty), 32'd1);
        cycle(1'b0, '0, 1'b1);
        check("udf_rd_err", 32'(rd_err), 32'd1);
        check("udf_dout",   32'(dout),   32'h10);

        // Simultaneous read/write while full.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(8'h20 + i), 1'b0);
        cycle(1'b1, 8'hAA, 1'b1);
        check("fullrw_rd_ack", 32'(rd_ack), 32'd1);
        check("fullrw_wr_ack", 32'(wr_ack), 32'd1);
        check("fullrw_full",   32'(full),   32'd1);
        check("fullrw_dout",   32'(dout),   32'h20);
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, '0, 1'b1);
            if (i == DEPTH) check("aa_16th", 32'(dout), 32'hAA);
        end

        // Simultaneous read/write while empty: no fall-through.
        cycle(1'b1, 8'h55, 1'b1);
        check("emptyrw_rd_err", 32'(rd_err),       32'd1);
        check("emptyrw_wr_ack", 32'(wr_ack),       32'd1);
        check("emptyrw_aempty", 32'(almost_empty), 32'd1);
        cycle(1'b0, '0, 1'b1);
        check("emptyrw_dout", 32'(dout), 32'h55);

        // Mixed traffic checked by the model alone.
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset mid-operation discards stored data.
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        cycle(1'b1, 8'h03, 1'b0);
        #2 clear_n = 1'b0;
        #1;
        check("midrst_empty",  32'(empty),        32'd1);
        check("midrst_aempty", 32'(almost_empty), 32'd0);
        model_reset();
        @(negedge clk);
        clear_n = 1'b1;
        cycle(1'b0, '0, 1'b1);
        check("midrst_rd_err", 32'(rd_err), 32'd1);
        check("midrst_rd_ack", 32'(rd_ack), 32'd0);

        cycle(1'b0, '0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
